// File: rtl/uart_bus_responder.sv
// Bus-side UART: answers CPU rdn/wrn strobes from RX/TX holding registers and
// runs an 8N1 receiver on rxd and transmitter on txd.
module uart_bus_responder #(
   parameter int CLK_DIV  = 434,
   parameter int SYNC_LEN = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rdn,
   input  logic       wrn,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       data_oe,
   output logic       data_ready,
   output logic       tbre,
   output logic       tsre,
   output logic       overrun,
   output logic       frame_err,
   input  logic       rxd,
   output logic       txd
);

   localparam int            CW       = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] BIT_CNT  = CW'(CLK_DIV);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

   logic [SYNC_LEN-1:0] rdn_sync_q, wrn_sync_q, rxd_sync_q;
   logic                rdn_prev_q, wrn_prev_q, rxd_prev_q;
   logic                rdn_s, wrn_s, rxd_s, rdn_rise, wrn_rise, rxd_fall;

   assign rdn_s    = rdn_sync_q[SYNC_LEN-1];
   assign wrn_s    = wrn_sync_q[SYNC_LEN-1];
   assign rxd_s    = rxd_sync_q[SYNC_LEN-1];
   assign rdn_rise = rdn_s & ~rdn_prev_q;
   assign wrn_rise = wrn_s & ~wrn_prev_q;
   assign rxd_fall = ~rxd_s & rxd_prev_q;

   // NOTE: synchronizers and edge history reset to the idle level (1) so leaving reset never looks like an edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdn_sync_q <= '1;
         wrn_sync_q <= '1;
         rxd_sync_q <= '1;
         rdn_prev_q <= 1'b1;
         wrn_prev_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every flop sample its predecessor's pre-edge value.
         rdn_sync_q <= {rdn_sync_q[SYNC_LEN-2:0], rdn};
         wrn_sync_q <= {wrn_sync_q[SYNC_LEN-2:0], wrn};
         rxd_sync_q <= {rxd_sync_q[SYNC_LEN-2:0], rxd};
         rdn_prev_q <= rdn_s;
         wrn_prev_q <= wrn_s;
         rxd_prev_q <= rxd_s;
      end
   end

   uart_state_e   tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [7:0]    staging_q, staging_d, tx_hold_q, tx_hold_d, tx_shift_q, tx_shift_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic          tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d, tx_load;

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      staging_d  = staging_q;
      tx_hold_d  = tx_hold_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tbre_d     = tbre_q;
      tsre_d     = tsre_q;
      txd_d      = txd_q;
      tx_load    = 1'b0;

      if (!wrn_s) staging_d = data_i;
      // A write while the holding register is still full is silently dropped.
      if (wrn_rise && tbre_q) begin
         tx_hold_d = staging_q;
         tbre_d    = 1'b0;
      end
      if (tx_state_q != ST_IDLE && tx_cnt_q != CNT_ONE) tx_cnt_d = tx_cnt_q - CNT_ONE;

      case (tx_state_q)
         ST_IDLE:  tx_load = !tbre_q;
         ST_START: if (tx_cnt_q == CNT_ONE) begin
            tx_state_d = ST_DATA;
            tx_cnt_d   = BIT_CNT;
            tx_bit_d   = '0;
            txd_d      = tx_shift_q[0];
         end
         ST_DATA: if (tx_cnt_q == CNT_ONE) begin
            tx_cnt_d = BIT_CNT;
            if (tx_bit_q == 3'd7) begin
               tx_state_d = ST_STOP;
               txd_d      = 1'b1;
            end else begin
               tx_bit_d   = tx_bit_q + 3'd1;
               tx_shift_d = tx_shift_q >> 1;
               txd_d      = tx_shift_q[1];
            end
         end
         ST_STOP: if (tx_cnt_q == CNT_ONE) begin
            if (!tbre_q) begin
               tx_load = 1'b1;
            end else begin
               tx_state_d = ST_IDLE;
               tsre_d     = 1'b1;
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase

      // Shared by IDLE and end-of-STOP so queued bytes go out with no idle gap.
      if (tx_load) begin
         tx_shift_d = tx_hold_q;
         tbre_d     = 1'b1;
         tsre_d     = 1'b0;
         txd_d      = 1'b0;
         tx_cnt_d   = BIT_CNT;
         tx_state_d = ST_START;
      end
   end

   uart_state_e   rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [7:0]    rx_shift_q, rx_shift_d, rx_hold_q, rx_hold_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic          ready_q, ready_d, overrun_q, overrun_d, ferr_q, ferr_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_shift_d = rx_shift_q;
      rx_hold_d  = rx_hold_q;
      rx_bit_d   = rx_bit_q;
      ready_d    = ready_q;
      overrun_d  = overrun_q;
      ferr_d     = 1'b0;

      if (rdn_rise) begin
         ready_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (rx_state_q != ST_IDLE && rx_cnt_q != CNT_ONE) rx_cnt_d = rx_cnt_q - CNT_ONE;

      case (rx_state_q)
         ST_IDLE: if (rxd_fall) begin
            rx_state_d = ST_START;
            rx_cnt_d   = HALF_CNT;
         end
         ST_START: if (rx_cnt_q == CNT_ONE) begin
            rx_state_d = rxd_s ? ST_IDLE : ST_DATA;
            rx_cnt_d   = BIT_CNT;
            rx_bit_d   = '0;
         end
         ST_DATA: if (rx_cnt_q == CNT_ONE) begin
            rx_shift_d = {rxd_s, rx_shift_q[7:1]};
            rx_cnt_d   = BIT_CNT;
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
         end
         ST_STOP: if (rx_cnt_q == CNT_ONE) begin
            rx_state_d = ST_IDLE;
            if (rxd_s) begin
               // A byte landing on the same cycle as a read wins over the read's clear.
               rx_hold_d = rx_shift_q;
               ready_d   = 1'b1;
               overrun_d = rdn_rise ? 1'b0 : (overrun_q | ready_q);
            end else begin
               ferr_d = 1'b1;
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         staging_q  <= '0;
         tx_hold_q  <= '0;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tbre_q     <= 1'b1;
         tsre_q     <= 1'b1;
         txd_q      <= 1'b1;
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_shift_q <= '0;
         rx_hold_q  <= '0;
         rx_bit_q   <= '0;
         ready_q    <= 1'b0;
         overrun_q  <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         staging_q  <= staging_d;
         tx_hold_q  <= tx_hold_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         tbre_q     <= tbre_d;
         tsre_q     <= tsre_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_hold_q  <= rx_hold_d;
         rx_bit_q   <= rx_bit_d;
         ready_q    <= ready_d;
         overrun_q  <= overrun_d;
         ferr_q     <= ferr_d;
      end
   end

   assign data_o     = rx_hold_q;
   assign data_oe    = ~rdn_s;
   assign data_ready = ready_q;
   assign tbre       = tbre_q;
   assign tsre       = tsre_q;
   assign overrun    = overrun_q;
   assign frame_err  = ferr_q;
   assign txd        = txd_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: TX frames and bus reads are checked
// by monitors against queues filled when stimulus is issued.
module tb_uart_bus_responder;

   localparam int CLK_DIV  = 4;
   localparam int SYNC_LEN = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       rdn = 1'b1;
   logic       wrn = 1'b1;
   logic [7:0] data_i = 8'h00;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rxd;
   logic [7:0] data_o;
   logic       data_oe, data_ready, tbre, tsre, overrun, frame_err, txd;

   assign rxd = loop_en ? txd : rxd_drv;

   uart_bus_responder #(.CLK_DIV(CLK_DIV), .SYNC_LEN(SYNC_LEN)) dut (
      .CLK(CLK), .RST(RST), .rdn(rdn), .wrn(wrn), .data_i(data_i),
      .data_o(data_o), .data_oe(data_oe), .data_ready(data_ready),
      .tbre(tbre), .tsre(tsre), .overrun(overrun), .frame_err(frame_err),
      .rxd(rxd), .txd(txd)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   int         tx_starts[$];
   int         fe_count = 0;
   int         fe_long  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // TX monitor: collects 10 bit-times (40 samples) per frame and decodes them.
   logic       tx_s[40];
   int         tx_n = 0;
   bit         tx_act = 1'b0;
   bit         tx_ok;
   logic [7:0] tx_got;
   always @(negedge CLK) begin
      if (!RST) begin
         tx_act = 1'b0;
      end else if (!tx_act) begin
         if (txd === 1'b0) begin
            tx_act = 1'b1;
            tx_s[0] = 1'b0;
            tx_n = 1;
            tx_starts.push_back(cyc);
         end
      end else begin
         tx_s[tx_n] = txd;
         tx_n++;
         if (tx_n == 40) begin
            tx_act = 1'b0;
            tx_ok = (tx_s[0] === 1'b0) && (tx_s[36] === 1'b1);
            for (int b = 0; b < 10; b++)
               for (int s = 1; s < CLK_DIV; s++)
                  if (tx_s[4*b+s] !== tx_s[4*b]) tx_ok = 1'b0;
            for (int i = 0; i < 8; i++) tx_got[i] = tx_s[4+4*i];
            check("tx_frame_shape", 32'(tx_ok), 1);
            if (tx_exp.size() == 0) check("tx_unexpected_frame", 32'(tx_got), 32'h100);
            else check("tx_byte", 32'(tx_got), 32'(tx_exp.pop_front()));
         end
      end
   end

   // Read monitor: every rising data_oe presents one RX byte on the bus.
   logic oe_prev = 1'b0;
   always @(negedge CLK) begin
      if (data_oe === 1'b1 && oe_prev !== 1'b1) begin
         if (rx_exp.size() == 0) check("rx_unexpected_read", 32'(data_o), 32'h100);
         else check("rx_read_data", 32'(data_o), 32'(rx_exp.pop_front()));
      end
      oe_prev = data_oe;
   end

   logic fe_prev = 1'b0;
   always @(negedge CLK) begin
      if (frame_err === 1'b1) fe_count++;
      if (frame_err === 1'b1 && fe_prev === 1'b1) fe_long++;
      fe_prev = frame_err;
   end

   function automatic logic sig(input int sel);
      case (sel)
         0:       return data_ready;
         1:       return tsre;
         default: return tbre;
      endcase
   endfunction

   task automatic wait_for(input string nm, input int sel, input logic val, input int budget);
      logic s;
      s = 1'bx;
      for (int n = 0; n < budget; n++) begin
         @(negedge CLK);
         s = sig(sel);
         if (s === val) break;
      end
      check(nm, 32'(s), 32'(val));
   endtask

   task automatic write_byte(input logic [7:0] b, output int rel);
      @(posedge CLK); #1;
      data_i = b;
      wrn = 1'b0;
      repeat (3) @(posedge CLK);
      #1 wrn = 1'b1;
      rel = cyc;
      repeat (2) @(posedge CLK);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1 rxd_drv = fr[i];
         repeat (CLK_DIV - 1) @(posedge CLK);
      end
      @(posedge CLK); #1 rxd_drv = 1'b1;
      repeat (2) @(posedge CLK);
   endtask

   task automatic read_rx();
      @(posedge CLK); #1 rdn = 1'b0;
      repeat (3) @(posedge CLK);
      #1 rdn = 1'b1;
      repeat (4) @(posedge CLK);
   endtask

   int         rel, j, t_tbre, t_txd, t_tsre, fe0, nf;
   logic       tsre_at4, tbre_at4;
   logic [7:0] rb[2];

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset_outputs", 32'({data_o, data_oe, data_ready, tbre, tsre, overrun, frame_err, txd}),
            32'({8'h00, 7'b0011001}));
      @(posedge CLK); #1 RST = 1'b1;
      repeat (5) @(posedge CLK);

      // Single write: latency from wrn release, tbre pulse, tsre span.
      tx_exp.push_back(8'hA5);
      write_byte(8'hA5, rel);
      t_tbre = -1; t_txd = -1; t_tsre = -1;
      tsre_at4 = 1'bx; tbre_at4 = 1'bx;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         j = cyc - rel;
         if (t_tbre < 0 && tbre === 1'b0) t_tbre = j;
         if (t_txd < 0 && txd === 1'b0) t_txd = j;
         if (t_txd >= 0 && t_tsre < 0 && tsre === 1'b1) t_tsre = j;
         if (j == 4) begin tsre_at4 = tsre; tbre_at4 = tbre; end
      end
      check("t1_tbre_low_cycle", t_tbre, 3);
      check("t1_start_bit_latency", t_txd, 4);
      check("t1_tsre_low_at_start", 32'(tsre_at4), 0);
      check("t1_tbre_refilled", 32'(tbre_at4), 1);
      check("t1_tsre_high_cycle", t_tsre, 44);

      // Back-to-back writes chain; a third write while the holding reg is full is dropped.
      tx_starts.delete();
      tx_exp.push_back(8'h01);
      tx_exp.push_back(8'h80);
      write_byte(8'h01, rel);
      write_byte(8'h80, rel);
      write_byte(8'hFF, rel);
      wait_for("t2_tsre_done", 1, 1'b1, 120);
      repeat (60) @(posedge CLK);
      check("t2_frame_count", tx_starts.size(), 2);
      if (tx_starts.size() >= 2) check("t2_frame_spacing", tx_starts[1] - tx_starts[0], 40);
      check("t2_tx_pending", tx_exp.size(), 0);

      // Receive and read one byte.
      rx_exp.push_back(8'h3C);
      send_rx(8'h3C, 1'b1);
      wait_for("t3_data_ready", 0, 1'b1, 20);
      check("t3_no_overrun", 32'(overrun), 0);
      read_rx();
      check("t3_ready_cleared", 32'(data_ready), 0);
      check("t3_oe_released", 32'(data_oe), 0);

      // Two bytes without a read: last byte kept, overrun set, read clears both.
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      wait_for("t4_data_ready", 0, 1'b1, 20);
      check("t4_overrun_set", 32'(overrun), 1);
      rx_exp.push_back(8'h22);
      read_rx();
      check("t4_ready_cleared", 32'(data_ready), 0);
      check("t4_overrun_cleared", 32'(overrun), 0);

      // Framing error, then a one-cycle glitch, then a clean byte.
      fe0 = fe_count;
      send_rx(8'h77, 1'b0);
      repeat (5) @(posedge CLK);
      check("t5_frame_err_pulse", fe_count - fe0, 1);
      check("t5_ready_after_ferr", 32'(data_ready), 0);
      @(posedge CLK); #1 rxd_drv = 1'b0;
      @(posedge CLK); #1 rxd_drv = 1'b1;
      repeat (20) @(posedge CLK);
      check("t5_glitch_no_ferr", fe_count - fe0, 1);
      check("t5_glitch_no_ready", 32'(data_ready), 0);
      rx_exp.push_back(8'hC3);
      send_rx(8'hC3, 1'b1);
      wait_for("t5_ready_after_glitch", 0, 1'b1, 20);
      read_rx();

      // Random receive bursts of one or two frames.
      for (int it = 0; it < 6; it++) begin
         nf = $urandom_range(1, 2);
         rb[0] = 8'($urandom_range(0, 255));
         rb[1] = 8'($urandom_range(0, 255));
         rx_exp.push_back(rb[nf-1]);
         for (int f = 0; f < nf; f++) send_rx(rb[f], 1'b1);
         wait_for("rnd_rx_ready", 0, 1'b1, 20);
         check("rnd_rx_overrun", 32'(overrun), 32'(nf > 1));
         read_rx();
         check("rnd_rx_ready_cleared", 32'(data_ready), 0);
      end

      // Random transmit bytes with random gaps.
      for (int it = 0; it < 6; it++) begin
         rb[0] = 8'($urandom_range(0, 255));
         tx_exp.push_back(rb[0]);
         write_byte(rb[0], rel);
         wait_for("rnd_tx_busy", 1, 1'b0, 10);
         wait_for("rnd_tx_done", 1, 1'b1, 60);
         repeat ($urandom_range(0, 5)) @(posedge CLK);
      end
      check("rnd_tx_pending", tx_exp.size(), 0);

      // Reset in the middle of a TX frame and an RX frame.
      send_rx(8'h99, 1'b1);
      check("t6_ready_before_reset", 32'(data_ready), 1);
      write_byte(8'h3F, rel);
      repeat (8) @(posedge CLK);
      fork
         send_rx(8'h44, 1'b1);
         begin
            repeat (12) @(posedge CLK);
            #2 RST = 1'b0;
            @(negedge CLK);
            check("t6_reset_outputs",
                  32'({data_o, data_oe, data_ready, tbre, tsre, overrun, frame_err, txd}),
                  32'({8'h00, 7'b0011001}));
         end
      join
      @(posedge CLK); #1 RST = 1'b1;
      tx_exp.delete();
      rx_exp.delete();
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      check("t6_idle_after_reset", 32'({data_ready, tbre, tsre, txd}), 32'(4'b0111));

      // Loopback txd -> rxd.
      loop_en = 1'b1;
      tx_exp.push_back(8'h5A);
      rx_exp.push_back(8'h5A);
      write_byte(8'h5A, rel);
      wait_for("t6_loop_ready", 0, 1'b1, 120);
      read_rx();
      loop_en = 1'b0;

      repeat (20) @(posedge CLK);
      check("final_tx_pending", tx_exp.size(), 0);
      check("final_rx_pending", rx_exp.size(), 0);
      check("frame_err_single_cycle", fe_long, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: time limit reached, got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
